// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrates, launches
// one operation per three cycles and returns the captured result with a done pulse.
module alu_arbiter #(
    parameter int PRIO_FIXED = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic [2:0] ops0,
    input  logic [2:0] ops1,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_ops,
    input  logic [4:0] alu_r,
    output logic [4:0] res,
    output logic       err,
    output logic       done0,
    output logic       done1,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    localparam bit RR = (PRIO_FIXED == 0);

    state_t     r_state;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [2:0] r_alu_ops;
    logic [4:0] r_res;
    logic       r_err;
    logic       r_done0;
    logic       r_done1;
    logic       r_busy;
    logic       r_win;
    logic       r_last;

    logic       w_grant1;
    logic       w_div0;

    // r_last == 1 means requester 1 was granted last, so requester 0 takes a round-robin tie.
    assign w_grant1 = req1 & (~req0 | (RR & ~r_last));
    assign w_div0   = ((r_alu_ops == 3'd3) || (r_alu_ops == 3'd4)) && (r_alu_b == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_ops <= '0;
            r_res     <= '0;
            r_err     <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_busy    <= 1'b0;
            r_win     <= 1'b0;
            r_last    <= 1'b1;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_win     <= w_grant1;
                        r_last    <= w_grant1;
                        r_alu_a   <= w_grant1 ? a1 : a0;
                        r_alu_b   <= w_grant1 ? b1 : b0;
                        r_alu_ops <= w_grant1 ? ops1 : ops0;
                        r_busy    <= 1'b1;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_err   <= w_div0;
                    r_res   <= w_div0 ? '0 : alu_r;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done0 <= ~r_win;
                    r_done1 <= r_win;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign alu_ops = r_alu_ops;
    assign res     = r_res;
    assign err     = r_err;
    assign done0   = r_done0;
    assign done1   = r_done1;
    assign busy    = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority instance
// share the request inputs, each wired to its own model of the shared ALU.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic [2:0] ops0, ops1;

    logic [3:0] rr_alu_a, rr_alu_b, fx_alu_a, fx_alu_b;
    logic [2:0] rr_alu_ops, fx_alu_ops;
    logic [4:0] rr_alu_r, fx_alu_r, rr_res, fx_res;
    logic       rr_err, rr_done0, rr_done1, rr_busy;
    logic       fx_err, fx_done0, fx_done1, fx_busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Shared ALU; division by zero returns all ones so the forced-zero result is visible.
    function automatic logic [4:0] alu_model(logic [3:0] a, logic [3:0] b, logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a};
            3'd1:    return {1'b0, a} + {1'b0, b};
            3'd2:    return {1'b0, a} - {1'b0, b};
            3'd3:    return (b == 4'd0) ? 5'h1F : {1'b0, a / b};
            3'd4:    return (b == 4'd0) ? 5'h1F : {1'b0, a % b};
            3'd5:    return {a, 1'b0};
            3'd6:    return {2'b00, a[3:1]};
            default: return (a > b) ? 5'd1 : 5'd0;
        endcase
    endfunction

    assign rr_alu_r = alu_model(rr_alu_a, rr_alu_b, rr_alu_ops);
    assign fx_alu_r = alu_model(fx_alu_a, fx_alu_b, fx_alu_ops);

    alu_arbiter #(.PRIO_FIXED(0)) u_rr (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ops0(ops0), .ops1(ops1),
        .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_ops(rr_alu_ops), .alu_r(rr_alu_r),
        .res(rr_res), .err(rr_err), .done0(rr_done0), .done1(rr_done1), .busy(rr_busy)
    );

    alu_arbiter #(.PRIO_FIXED(1)) u_fx (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ops0(ops0), .ops1(ops1),
        .alu_a(fx_alu_a), .alu_b(fx_alu_b), .alu_ops(fx_alu_ops), .alu_r(fx_alu_r),
        .res(fx_res), .err(fx_err), .done0(fx_done0), .done1(fx_done1), .busy(fx_busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " rr alu_a"},   int'(rr_alu_a),   0);
        chk({tag, " rr alu_b"},   int'(rr_alu_b),   0);
        chk({tag, " rr alu_ops"}, int'(rr_alu_ops), 0);
        chk({tag, " rr res"},     int'(rr_res),     0);
        chk({tag, " rr err"},     int'(rr_err),     0);
        chk({tag, " rr done0"},   int'(rr_done0),   0);
        chk({tag, " rr done1"},   int'(rr_done1),   0);
        chk({tag, " rr busy"},    int'(rr_busy),    0);
        chk({tag, " fx res"},     int'(fx_res),     0);
        chk({tag, " fx done"},    int'(fx_done0 | fx_done1), 0);
        chk({tag, " fx busy"},    int'(fx_busy),    0);
    endtask

    // Waits (bounded) on negedges for a done pulse from the chosen instance.
    task automatic wait_done(input bit sel_fx, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sel_fx ? (fx_done0 | fx_done1) : (rr_done0 | rr_done1)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({name, " timeout"}, 0, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int r0, r1;
        int a0, b0, o0;
        int a1, b1, o1;
        int d0, d1, res, err;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rr, n_fx;
        int rr_who[8], rr_r[8], fx_who[8], fx_r[8];

        vecs[0]  = '{1, 0, 14, 7, 1,  0, 0, 0,  1, 0, 21, 0};
        vecs[1]  = '{0, 1,  0, 0, 0,  9, 0, 3,  0, 1,  0, 1};
        vecs[2]  = '{0, 1,  0, 0, 0,  9, 0, 4,  0, 1,  0, 1};
        vecs[3]  = '{1, 0, 14, 7, 0,  0, 0, 0,  1, 0, 14, 0};
        vecs[4]  = '{1, 0, 14, 7, 1,  0, 0, 0,  1, 0, 21, 0};
        vecs[5]  = '{1, 0, 14, 7, 2,  0, 0, 0,  1, 0,  7, 0};
        vecs[6]  = '{1, 0, 14, 7, 3,  0, 0, 0,  1, 0,  2, 0};
        vecs[7]  = '{1, 0, 14, 7, 4,  0, 0, 0,  1, 0,  0, 0};
        vecs[8]  = '{1, 0, 14, 7, 5,  0, 0, 0,  1, 0, 28, 0};
        vecs[9]  = '{1, 0, 14, 7, 6,  0, 0, 0,  1, 0,  7, 0};
        vecs[10] = '{1, 0, 14, 7, 7,  0, 0, 0,  1, 0,  1, 0};
        vecs[11] = '{0, 1,  0, 0, 0,  9, 2, 3,  0, 1,  4, 0};
        vecs[12] = '{1, 0,  3, 0, 1,  0, 0, 0,  1, 0,  3, 0};
        vecs[13] = '{0, 1,  0, 0, 0, 15, 15, 1, 0, 1, 30, 0};
        vecs[14] = '{1, 0,  3, 5, 2,  0, 0, 0,  1, 0, 30, 0};

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; ops0 = '0; ops1 = '0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            req0 = vecs[i].r0[0];
            req1 = vecs[i].r1[0];
            a0 = 4'(vecs[i].a0); b0 = 4'(vecs[i].b0); ops0 = 3'(vecs[i].o0);
            a1 = 4'(vecs[i].a1); b1 = 4'(vecs[i].b1); ops1 = 3'(vecs[i].o1);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d busy", i), int'(rr_busy), 1);
            @(negedge clk);
            chk($sformatf("v%0d early done", i), int'(rr_done0 | rr_done1), 0);
            @(negedge clk);
            chk($sformatf("v%0d rr done0", i), int'(rr_done0), vecs[i].d0);
            chk($sformatf("v%0d rr done1", i), int'(rr_done1), vecs[i].d1);
            chk($sformatf("v%0d rr res", i),   int'(rr_res),   vecs[i].res);
            chk($sformatf("v%0d rr err", i),   int'(rr_err),   vecs[i].err);
            chk($sformatf("v%0d fx done0", i), int'(fx_done0), vecs[i].d0);
            chk($sformatf("v%0d fx done1", i), int'(fx_done1), vecs[i].d1);
            chk($sformatf("v%0d fx res", i),   int'(fx_res),   vecs[i].res);
            chk($sformatf("v%0d fx err", i),   int'(fx_err),   vecs[i].err);
            req0 = 1'b0;
            req1 = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d done width", i), int'(rr_done0 | rr_done1), 0);
            chk($sformatf("v%0d idle busy", i), int'(rr_busy), 0);
        end

        // Both requesters held: round-robin alternates, fixed priority starves requester 1.
        pulse_reset();
        req0 = 1'b1; a0 = 4'd14; b0 = 4'd7; ops0 = 3'd2;
        req1 = 1'b1; a1 = 4'd3;  b1 = 4'd5; ops1 = 3'd7;
        n_rr = 0;
        n_fx = 0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            chk("rr done exclusive", int'(rr_done0 & rr_done1), 0);
            chk("fx done exclusive", int'(fx_done0 & fx_done1), 0);
            if ((rr_done0 | rr_done1) && n_rr < 8) begin
                rr_who[n_rr] = int'(rr_done1);
                rr_r[n_rr]   = int'(rr_res);
                n_rr++;
            end
            if ((fx_done0 | fx_done1) && n_fx < 8) begin
                fx_who[n_fx] = int'(fx_done1);
                fx_r[n_fx]   = int'(fx_res);
                n_fx++;
            end
        end
        chk("rr grant count", n_rr, 4);
        chk("fx grant count", n_fx, 4);
        for (int k = 0; k < n_rr && k < 4; k++) begin
            chk($sformatf("rr grant %0d who", k), rr_who[k], k % 2);
            chk($sformatf("rr grant %0d res", k), rr_r[k], (k % 2 == 0) ? 7 : 0);
        end
        for (int k = 0; k < n_fx && k < 4; k++) begin
            chk($sformatf("fx grant %0d who", k), fx_who[k], 0);
            chk($sformatf("fx grant %0d res", k), fx_r[k], 7);
        end
        wait_done(1'b1, "fx before drop");
        chk("fx pre-drop is done0", int'(fx_done0), 1);
        req0 = 1'b0;
        wait_done(1'b1, "fx after drop");
        chk("fx serves req1 done1", int'(fx_done1), 1);
        chk("fx serves req1 done0", int'(fx_done0), 0);
        chk("fx serves req1 res", int'(fx_res), 0);
        req1 = 1'b0;

        // Asynchronous reset mid-EXEC aborts the grant and restores the tie pointer.
        pulse_reset();
        req0 = 1'b1; a0 = 4'd14; b0 = 4'd7; ops0 = 3'd1;
        wait_done(1'b0, "pre-abort op");
        chk("pre-abort done0", int'(rr_done0), 1);
        req0 = 1'b0;
        @(negedge clk);
        req0 = 1'b1;
        req1 = 1'b1; a1 = 4'd9; b1 = 4'd2; ops1 = 3'd3;
        @(posedge clk);
        @(negedge clk);
        chk("abort busy before rst", int'(rr_busy), 1);
        chk("abort grant to req1", int'(rr_alu_a), 9);
        #2 rst = 1'b1;
        #1 chk_zero("async rst");
        @(negedge clk);
        rst = 1'b0;
        wait_done(1'b0, "post-abort op");
        chk("post-abort done0", int'(rr_done0), 1);
        chk("post-abort done1", int'(rr_done1), 0);
        chk("post-abort res", int'(rr_res), 21);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001: Parameter PRIO_FIXED, default 0; 0 = round-robin between requesters, 1 = requester 0 always wins a tie.
REQ-002: clk  input  1  single system clock, all state updates on rising edge.
REQ-003: rst  input  1  reset, asynchronous, active-high.
REQ-004: req0 / req1  input  1 each  request from requester 0 / 1, held high until its done pulse.
REQ-005: a0, b0 / a1, b1  input  4 each  operands of requester 0 / 1, stable while the matching req is high.
REQ-006: ops0 / ops1  input  3 each  ALU op code (0 pass a, 1 add, 2 sub, 3 div, 4 mod, 5 shl1, 6 shr1, 7 a>b).
REQ-007: alu_a, alu_b  output  4 each  registered operands driven to the shared combinational ALU.
REQ-008: alu_ops  output  3  registered op code driven to the shared ALU.
REQ-009: alu_r  input  5  combinational result returned by the shared ALU.
REQ-010: res  output  5  captured result, valid while a done pulse is high.
REQ-011: err  output  1  high with done when op is 3 or 4 and the operand b is 0.
REQ-012: done0 / done1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-013: busy  output  1  high in every state except IDLE.

Function
REQ-014: FSM states IDLE, EXEC, DONE; IDLE -> EXEC when req0 or req1 high; EXEC -> DONE unconditionally; DONE -> IDLE unconditionally.
REQ-015: In IDLE with a request: select winner, load alu_a/alu_b/alu_ops from winner's inputs, record winner id.
REQ-016: Single request: that requester wins regardless of PRIO_FIXED.
REQ-017: Both requests, PRIO_FIXED=1: requester 0 wins.
REQ-018: Both requests, PRIO_FIXED=0: requester not granted most recently wins; last-grant pointer updates on each grant.
REQ-019: In EXEC: res <= alu_r; err <= (alu_ops==3 or 4) and alu_b==0.
REQ-020: On err, res SHALL be forced to 5'b00000 instead of alu_r.
REQ-021: In DONE: done pulse of the recorded winner high for exactly one cycle; other done low; res/err hold.
REQ-022: Latency: request sampled in IDLE at edge N -> done high during cycle after edge N+2; throughput one operation per 3 cycles.
REQ-023: A req still high in IDLE after its done pulse is treated as a new request.
REQ-024: Requests arriving while busy are not sampled until IDLE; no request is dropped while its req stays high.
REQ-025: res, err, alu_* change only on the transitions above; held otherwise.
REQ-026: done0 and done1 SHALL never be high in the same cycle.

Reset
REQ-027: rst high forces state IDLE immediately, independent of clk.
REQ-028: Reset values: alu_a=0, alu_b=0, alu_ops=0, res=0, err=0, done0=0, done1=0, busy=0.
REQ-029: Reset sets last-grant pointer to requester 1, so requester 0 wins the first tie.
REQ-030: Reset during EXEC or DONE aborts the operation; no done pulse is issued for it.

Verification
REQ-031: req0 only, a0=4'b1110, b0=4'b0111, ops0=1 -> done0 pulse 3 cycles later, res=5'b10101, err=0, done1=0.
REQ-032: req1 only, a1=9, b1=0, ops1=3 -> done1 pulse, err=1, res=0; repeat with ops1=4 -> same.
REQ-033: PRIO_FIXED=0, req0 and req1 held high after reset (ops0=2 a0=14 b0=7, ops1=7 a1=3 b1=5) -> done0 (res=7), done1 (res=0), done0, done1 alternating.
REQ-034: PRIO_FIXED=1, both held high -> every grant to requester 0 until req0 drops, then requester 1 served.
REQ-035: Assert rst asynchronously mid-EXEC -> all outputs 0 at once, no done pulse; after release, pending req0 served with first tie to requester 0.
REQ-036: Sweep ops 0..7 on requester 0 with a=14, b=7 -> res 14, 21, 7, 2, 0, 28, 7, 1 respectively, matched against the shared ALU.
